// File: rtl/cpu_pio_pkg.sv
// Shared constants for the cpu_pio_out_blink Avalon-MM output PIO:
// register addresses, STATUS bit positions and the PWM counter width.
package cpu_pio_pkg;
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE = 3'd3;
  localparam logic [2:0] ADDR_MASK   = 3'd4;
  localparam logic [2:0] ADDR_DIV    = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;
  localparam logic [2:0] ADDR_PWM    = 3'd7;

  localparam int STATUS_PHASE_BIT = 0;
  localparam int STATUS_MASK_BIT  = 1;

  localparam int PWM_W = 8;
endpackage

// File: rtl/cpu_pio_blink_timer.sv
// Blink phase generator (half-period divider) plus the optional PWM counter,
// enabled by defining CPU_PIO_OUT_BLINK_PWM_EN.
module cpu_pio_blink_timer
  import cpu_pio_pkg::*;
#(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_div_load,
  input  logic [DIV_W-1:0] i_blink_div,
`ifdef CPU_PIO_OUT_BLINK_PWM_EN
  input  logic [PWM_W-1:0] i_pwm_duty,
`endif
  output logic             o_phase,
  output logic             o_pwm_on
);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_phase;
  logic             w_term;

  assign w_term = (r_div_cnt == i_blink_div);

  // A divider load restarts the half-period and wins over a terminal count.
  always_ff @(posedge clk) begin
    if (reset || i_div_load) begin
      r_div_cnt <= '0;
      r_phase   <= 1'b1;
    end else if (w_term) begin
      r_div_cnt <= '0;
      r_phase   <= ~r_phase;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign o_phase = r_phase;

`ifdef CPU_PIO_OUT_BLINK_PWM_EN
  logic [PWM_W-1:0] r_pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) r_pwm_cnt <= '0;
    else       r_pwm_cnt <= r_pwm_cnt + 1'b1;
  end

  // Full-scale duty is forced on so that 8'hFF means continuously lit.
  assign o_pwm_on = (i_pwm_duty == {PWM_W{1'b1}}) || (r_pwm_cnt < i_pwm_duty);
`else
  assign o_pwm_on = 1'b1;
`endif

endmodule

// File: rtl/cpu_pio_out_blink.sv
// WIDTH-channel Avalon-MM output PIO with set/clear/toggle and hardware blink.
// Optional PWM dimming at address 7 when CPU_PIO_OUT_BLINK_PWM_EN is defined.
module cpu_pio_out_blink
  import cpu_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DIV_W       = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_blink_mask;
  logic [DIV_W-1:0] r_blink_div;
  logic             w_wr;
  logic             w_div_load;
  logic [WIDTH-1:0] w_wd;
  logic             w_phase;
  logic             w_pwm_on;
  logic [31:0]      w_rd;
  logic             w_unused;

  assign w_wr       = chipselect & ~write_n;
  assign w_wd       = writedata[WIDTH-1:0];
  assign w_div_load = w_wr && (address == ADDR_DIV);
  assign w_unused   = &{1'b0, writedata};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data       <= RESET_VALUE;
      r_blink_mask <= '0;
      r_blink_div  <= '0;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:   r_data       <= w_wd;
        ADDR_SET:    r_data       <= r_data | w_wd;
        ADDR_CLEAR:  r_data       <= r_data & ~w_wd;
        ADDR_TOGGLE: r_data       <= r_data ^ w_wd;
        ADDR_MASK:   r_blink_mask <= w_wd;
        ADDR_DIV:    r_blink_div  <= writedata[DIV_W-1:0];
        default:     ;
      endcase
    end
  end

`ifdef CPU_PIO_OUT_BLINK_PWM_EN
  logic [PWM_W-1:0] r_pwm_duty;

  always_ff @(posedge clk) begin
    if (reset)                               r_pwm_duty <= {PWM_W{1'b1}};
    else if (w_wr && (address == ADDR_PWM))  r_pwm_duty <= writedata[PWM_W-1:0];
  end
`endif

  cpu_pio_blink_timer #(
    .DIV_W(DIV_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_div_load (w_div_load),
    .i_blink_div(r_blink_div),
`ifdef CPU_PIO_OUT_BLINK_PWM_EN
    .i_pwm_duty (r_pwm_duty),
`endif
    .o_phase    (w_phase),
    .o_pwm_on   (w_pwm_on)
  );

  always_comb begin
    w_rd = '0;
    case (address)
      ADDR_DATA:   w_rd[WIDTH-1:0] = r_data;
      ADDR_MASK:   w_rd[WIDTH-1:0] = r_blink_mask;
      ADDR_DIV:    w_rd[DIV_W-1:0] = r_blink_div;
      ADDR_STATUS: begin
        w_rd[STATUS_PHASE_BIT] = w_phase;
        w_rd[STATUS_MASK_BIT]  = |r_blink_mask;
      end
`ifdef CPU_PIO_OUT_BLINK_PWM_EN
      ADDR_PWM:    w_rd[PWM_W-1:0] = r_pwm_duty;
`endif
      default:     w_rd = '0;
    endcase
  end

  assign readdata = chipselect ? w_rd : 32'd0;

  // Blinking channels are blanked during the off phase; PWM gates all channels.
  assign out_port = r_data & ~(r_blink_mask & {WIDTH{~w_phase}}) & {WIDTH{w_pwm_on}};

endmodule

// File: tb/tb_cpu_pio_out_blink.sv
// Self-checking bench for cpu_pio_out_blink (WIDTH=8, RESET_VALUE=8'hA5).
// Build with CPU_PIO_OUT_BLINK_PWM_EN defined to exercise the PWM sequences.
module tb_cpu_pio_out_blink;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [2:0]  ra;
    logic [7:0]  exp_out;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  cpu_pio_out_blink #(
    .WIDTH      (8),
    .DIV_W      (24),
    .RESET_VALUE(8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  task automatic push(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic check_pop(input logic [31:0] act);
    sb_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %h with nothing expected", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    #1;
    v          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    int          cnt;

    vecs[0] = '{3'd0, 32'h0000_000F, 3'd0, 8'h0F, 32'h0000_000F};
    vecs[1] = '{3'd1, 32'h0000_00F0, 3'd1, 8'hFF, 32'h0};
    vecs[2] = '{3'd2, 32'h0000_0081, 3'd2, 8'h7E, 32'h0};
    vecs[3] = '{3'd3, 32'h0000_0003, 3'd3, 8'h7D, 32'h0};
    vecs[4] = '{3'd6, 32'h0000_00FF, 3'd0, 8'h7D, 32'h0000_007D};
    vecs[5] = '{3'd0, 32'hFFFF_FFFF, 3'd0, 8'hFF, 32'h0000_00FF};
    vecs[6] = '{3'd4, 32'h0000_0000, 3'd4, 8'hFF, 32'h0};

    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    push("reset_out", 32'h0000_00A5);       check_pop({24'd0, out_port});
    push("idle_readdata", 32'h0);           check_pop(readdata);
    push("reset_rd_data", 32'h0000_00A5);   rd(3'd0, r); check_pop(r);
    push("reset_rd_status", 32'h1);         rd(3'd6, r); check_pop(r);

    for (int i = 0; i < 7; i++) begin
      push($sformatf("vec%0d_out", i), {24'd0, vecs[i].exp_out});
      push($sformatf("vec%0d_rd", i), vecs[i].exp_rd);
      wr(vecs[i].wa, vecs[i].wd);
      check_pop({24'd0, out_port});
      rd(vecs[i].ra, r);
      check_pop(r);
    end

    // Half-period 4: off for edges 4..7 after the divider load, on for 8..11.
    wr(3'd5, 32'd3);
    wr(3'd4, 32'h01);
    wr(3'd0, 32'hFF);
    for (int k = 2; k <= 13; k++) begin
      if (k > 2) step();
      push($sformatf("blink_k%0d", k), ((k / 4) % 2 == 0) ? 32'hFF : 32'hFE);
      check_pop({24'd0, out_port});
    end

    push("div_reload_out", 32'hFF);         wr(3'd5, 32'd3); check_pop({24'd0, out_port});
    push("div_readback", 32'd3);            rd(3'd5, r); check_pop(r);
    repeat (4) step();
    push("off_before_reset", 32'hFE);       check_pop({24'd0, out_port});

    reset = 1'b1;
    step();
    reset = 1'b0;
    push("midblink_reset_out", 32'hA5);     check_pop({24'd0, out_port});
    push("midblink_reset_status", 32'h1);   rd(3'd6, r); check_pop(r);
    push("midblink_reset_mask", 32'h0);     rd(3'd4, r); check_pop(r);
    push("midblink_reset_div", 32'h0);      rd(3'd5, r); check_pop(r);

    // Divider 0: phase flips on every edge after the load.
    wr(3'd5, 32'd0);
    wr(3'd4, 32'hFF);
    wr(3'd0, 32'hFF);
    for (int k = 2; k <= 7; k++) begin
      if (k > 2) step();
      push($sformatf("fast_out_k%0d", k), (k % 2 == 0) ? 32'hFF : 32'h00);
      check_pop({24'd0, out_port});
      push($sformatf("fast_status_k%0d", k), (k % 2 == 0) ? 32'h3 : 32'h2);
      rd(3'd6, r);
      check_pop(r);
    end

    wr(3'd4, 32'h00);
    wr(3'd0, 32'h01);
`ifdef CPU_PIO_OUT_BLINK_PWM_EN
    push("pwm_reset_duty", 32'hFF);         rd(3'd7, r); check_pop(r);
    for (int d = 0; d < 3; d++) begin
      logic [7:0] duty;
      duty = (d == 0) ? 8'd64 : (d == 1) ? 8'd0 : 8'd255;
      wr(3'd7, {24'd0, duty});
      cnt = 0;
      for (int c = 0; c < 256; c++) begin
        cnt += int'(out_port[0]);
        step();
      end
      push($sformatf("pwm_duty%0d_ontime", duty), (duty == 8'd255) ? 32'd256 : {24'd0, duty});
      check_pop(cnt);
    end
`else
    cnt = 0;
    push("addr7_rd", 32'h0);                wr(3'd7, 32'h12); rd(3'd7, r); check_pop(r);
    push("addr7_out", 32'h01);              check_pop({24'd0, out_port});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
